// File: rtl/sce_ram_arbiter.sv
// sce_ram_arbiter: round-robin arbiter for two SCE engine masters onto one
// single-port 1024x36 scratch RAM macro (active-low cen/gwen/wen, 1-cycle
// registered read). After reset, and on a zeroize pulse, the whole RAM is
// swept to zero before any grant is given.
//
// Optional feature, enabled by defining SCE_RAMARB_PARITY_EN:
//   per-byte even parity is stored in RAM bits DW+3:DW and checked on every
//   read return. A mismatch sets the sticky perr output. Without the macro
//   the parity bits are written as zero and perr is tied low.
//
// Handshake: a master raises req and holds we/addr/wdata/wmask stable until
// it sees gnt high. gnt is combinational, and the RAM access is issued in the
// same cycle as gnt. A granted read returns exactly one cycle later, as a
// single-cycle rvalid pulse with rdata on the same cycle. Writes have no
// response. The busy output is the debug view of the FSM: 1 = SCRUB, 0 = RUN.
module sce_ram_arbiter #(
  parameter int AW    = 10,
  parameter int DW    = 32,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          zeroize,
  output logic          busy,
  input  logic          m0_req,
  output logic          m0_gnt,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m0_wmask,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  output logic          m1_gnt,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [DW-1:0] m1_wmask,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          perr,
  output logic          ram_cen,
  output logic          ram_gwen,
  output logic [DW+3:0] ram_wen,
  output logic [AW-1:0] ram_a,
  output logic [DW+3:0] ram_d,
  input  logic [DW+3:0] ram_q
);

  typedef enum logic {ST_SCRUB = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        state_q;
  logic [AW-1:0] cnt_q;
  logic          busy_q;
  logic          last_gnt_q;   // 0 = m0 was granted last, 1 = m1
  logic          m0_rvalid_q;
  logic          m1_rvalid_q;
  logic          arb_en;
  logic          s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_wmask;

  // Grants only in RUN, never under reset, and zeroize wins over requests.
  assign arb_en = (state_q == ST_RUN) && !reset && !zeroize;
  assign m0_gnt = arb_en && m0_req && (!m1_req || last_gnt_q);
  assign m1_gnt = arb_en && m1_req && (!m0_req || !last_gnt_q);

  // Request mux: m1 fields only when m1 is granted, m0 otherwise.
  assign s_we    = m1_gnt ? m1_we    : m0_we;
  assign s_addr  = m1_gnt ? m1_addr  : m0_addr;
  assign s_wdata = m1_gnt ? m1_wdata : m0_wdata;
  assign s_wmask = m1_gnt ? m1_wmask : m0_wmask;

  assign busy      = busy_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = ram_q[DW-1:0];
  assign m1_rdata  = ram_q[DW-1:0];

`ifdef SCE_RAMARB_PARITY_EN
  logic perr_q;
  logic par_err;
  logic mask_ok;

  function automatic logic [3:0] byte_par(input logic [DW-1:0] w);
    logic [3:0] p;
    for (int k = 0; k < 4; k++) p[k] = ^w[8*k +: 8];
    return p;
  endfunction

  // Stored parity is checked only on cycles that return read data.
  assign par_err = (m0_rvalid_q || m1_rvalid_q) &&
                   (byte_par(ram_q[DW-1:0]) != ram_q[DW+3:DW]);
  assign perr    = perr_q || par_err;

  // Parity is kept per byte, so a write mask has to cover whole bytes.
  always_comb begin
    mask_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if ((s_wmask[8*k +: 8] != 8'h00) && (s_wmask[8*k +: 8] != 8'hFF)) mask_ok = 1'b0;
    end
  end

  // Flag a partial-byte write mask in simulation.
  always_ff @(posedge clk) begin
    if (!reset && (m0_gnt || m1_gnt) && s_we) begin
      assert (mask_ok) else $error("sce_ram_arbiter: partial-byte wmask %h", s_wmask);
    end
  end

  // Sticky parity error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) perr_q <= 1'b0;
    else       perr_q <= perr_q || par_err;
  end
`else
  logic unused_par;
  assign unused_par = ^ram_q[DW+3:DW];
  assign perr       = 1'b0;
`endif

  // RAM control: scrub write, granted access, or idle (cen high).
  always_comb begin
    ram_cen  = 1'b1;
    ram_gwen = 1'b1;
    ram_wen  = '1;
    ram_a    = s_addr;
    ram_d    = {4'b0000, s_wdata};
`ifdef SCE_RAMARB_PARITY_EN
    ram_d[DW+3:DW] = byte_par(s_wdata);
`endif
    if (!reset) begin
      if (state_q == ST_SCRUB) begin
        ram_cen  = 1'b0;
        ram_gwen = 1'b0;
        ram_wen  = '0;
        ram_a    = cnt_q;
        ram_d    = '0;
      end else if (m0_gnt || m1_gnt) begin
        ram_cen = 1'b0;
        if (s_we) begin
          ram_gwen          = 1'b0;
          ram_wen[DW-1:0]   = ~s_wmask;
`ifdef SCE_RAMARB_PARITY_EN
          for (int k = 0; k < 4; k++) ram_wen[DW+k] = ~s_wmask[8*k];
`else
          ram_wen[DW+3:DW]  = 4'b0000;
`endif
        end
      end
    end
  end

  // FSM (SCRUB sweep / RUN), round-robin pointer and read-return pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SCRUB;
      cnt_q       <= '0;
      busy_q      <= 1'b1;
      last_gnt_q  <= 1'b1;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      m0_rvalid_q <= m0_gnt && !m0_we;
      m1_rvalid_q <= m1_gnt && !m1_we;
      if (m0_gnt)      last_gnt_q <= 1'b0;
      else if (m1_gnt) last_gnt_q <= 1'b1;
      case (state_q)
        ST_SCRUB: begin
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        ST_RUN: begin
          if (zeroize) begin
            state_q <= ST_SCRUB;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_SCRUB;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sce_ram_arbiter.sv
// Testbench for sce_ram_arbiter: behavioural 1024x36 RAM macro model,
// table-driven single-cycle vectors, and directed sequences for the scrub
// sweep, zeroize and (when SCE_RAMARB_PARITY_EN is defined) parity error.
module tb_sce_ram_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 1024;

  logic          clk, reset, zeroize, busy, perr;
  logic          m0_req, m0_gnt, m0_we, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_wmask, m0_rdata;
  logic          m1_req, m1_gnt, m1_we, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_wmask, m1_rdata;
  logic          ram_cen, ram_gwen;
  logic [DW+3:0] ram_wen, ram_d, ram_q;
  logic [AW-1:0] ram_a;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];

  sce_ram_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .zeroize(zeroize), .busy(busy),
    .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .perr(perr), .ram_cen(ram_cen), .ram_gwen(ram_gwen), .ram_wen(ram_wen),
    .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM macro model ----------------
  // Preloaded with nonzero junk while reset is high so the sweep is visible.
  logic [DW+3:0] mem [0:DEPTH-1];
  logic [DW+3:0] q_reg;
  logic [DW+3:0] q_flip;
  assign ram_q = q_reg ^ q_flip;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= {4'hA, 32'h5A5A0000 | 32'(i)};
    end else if (!ram_cen) begin
      if (!ram_gwen) mem[ram_a] <= (mem[ram_a] & ram_wen) | (ram_d & ~ram_wen);
      else           q_reg <= mem[ram_a];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_m0(input logic req, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] k);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; m0_wmask = k;
  endtask

  task automatic drv_m1(input logic req, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] k);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; m1_wmask = k;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0, k0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1, k1;
    logic          eg0, eg1, ecen, egwen, erv0, erv1;
    logic [DW-1:0] erd;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(
      input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0, input logic [DW-1:0] k0,
      input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1, input logic [DW-1:0] k1,
      input logic eg0, input logic eg1, input logic ecen, input logic egwen,
      input logic erv0, input logic erv1, input logic [DW-1:0] erd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.k0 = k0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.k1 = k1;
    v.eg0 = eg0; v.eg1 = eg1; v.ecen = ecen; v.egwen = egwen;
    v.erv0 = erv0; v.erv1 = erv1; v.erd = erd;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    q_flip = '0;
    reset = 1'b1;
    zeroize = 1'b0;
    drv_m0(0, 0, '0, '0, '0);
    drv_m1(0, 0, '0, '0, '0);

    //            m0: req we addr    wdata         wmask          m1: req we addr    wdata         wmask          g0 g1 cen gwen rv0 rv1 rdata
    vecs[0]  = mk(1, 0, 10'h005, 32'h0,        32'h0,         0, 0, 10'h000, 32'h0,        32'h0,         1, 0, 0, 1, 0, 0, 32'h0);
    vecs[1]  = mk(0, 0, 10'h000, 32'h0,        32'h0,         0, 0, 10'h000, 32'h0,        32'h0,         0, 0, 1, 1, 1, 0, 32'h0);
    vecs[2]  = mk(1, 1, 10'h3FF, 32'hDEADBEEF, 32'hFFFFFFFF,  0, 0, 10'h000, 32'h0,        32'h0,         1, 0, 0, 0, 0, 0, 32'h0);
    vecs[3]  = mk(1, 0, 10'h3FF, 32'h0,        32'h0,         0, 0, 10'h000, 32'h0,        32'h0,         1, 0, 0, 1, 0, 0, 32'h0);
    vecs[4]  = mk(0, 0, 10'h000, 32'h0,        32'h0,         0, 0, 10'h000, 32'h0,        32'h0,         0, 0, 1, 1, 1, 0, 32'hDEADBEEF);
    vecs[5]  = mk(0, 0, 10'h000, 32'h0,        32'h0,         1, 1, 10'h010, 32'h12345678, 32'hFFFFFFFF,  0, 1, 0, 0, 0, 0, 32'h0);
    vecs[6]  = mk(1, 0, 10'h3FF, 32'h0,        32'h0,         1, 0, 10'h010, 32'h0,        32'h0,         1, 0, 0, 1, 0, 0, 32'h0);
    vecs[7]  = mk(1, 0, 10'h3FF, 32'h0,        32'h0,         1, 0, 10'h010, 32'h0,        32'h0,         0, 1, 0, 1, 1, 0, 32'hDEADBEEF);
    vecs[8]  = mk(1, 0, 10'h3FF, 32'h0,        32'h0,         1, 0, 10'h010, 32'h0,        32'h0,         1, 0, 0, 1, 0, 1, 32'h12345678);
    vecs[9]  = mk(1, 0, 10'h3FF, 32'h0,        32'h0,         1, 0, 10'h010, 32'h0,        32'h0,         0, 1, 0, 1, 1, 0, 32'hDEADBEEF);
    vecs[10] = mk(0, 0, 10'h000, 32'h0,        32'h0,         0, 0, 10'h000, 32'h0,        32'h0,         0, 0, 1, 1, 0, 1, 32'h12345678);
    vecs[11] = mk(0, 0, 10'h000, 32'h0,        32'h0,         1, 1, 10'h020, 32'hFFFFFFFF, 32'hFFFFFFFF,  0, 1, 0, 0, 0, 0, 32'h0);
    vecs[12] = mk(0, 0, 10'h000, 32'h0,        32'h0,         1, 1, 10'h020, 32'h00000000, 32'h0000FFFF,  0, 1, 0, 0, 0, 0, 32'h0);
    vecs[13] = mk(0, 0, 10'h000, 32'h0,        32'h0,         1, 0, 10'h020, 32'h0,        32'h0,         0, 1, 0, 1, 0, 0, 32'h0);
    vecs[14] = mk(0, 0, 10'h000, 32'h0,        32'h0,         0, 0, 10'h000, 32'h0,        32'h0,         0, 0, 1, 1, 0, 1, 32'hFFFF0000);
    vecs[15] = mk(1, 1, 10'h3FF, 32'h00000000, 32'h00000000,  0, 0, 10'h000, 32'h0,        32'h0,         1, 0, 0, 0, 0, 0, 32'h0);
    vecs[16] = mk(1, 0, 10'h3FF, 32'h0,        32'h0,         1, 1, 10'h020, 32'h0000ABCD, 32'h0000FFFF,  0, 1, 0, 0, 0, 0, 32'h0);
    vecs[17] = mk(1, 0, 10'h3FF, 32'h0,        32'h0,         0, 0, 10'h000, 32'h0,        32'h0,         1, 0, 0, 1, 0, 0, 32'h0);
    vecs[18] = mk(0, 0, 10'h000, 32'h0,        32'h0,         0, 0, 10'h000, 32'h0,        32'h0,         0, 0, 1, 1, 1, 0, 32'hDEADBEEF);
    vecs[19] = mk(0, 0, 10'h000, 32'h0,        32'h0,         1, 0, 10'h020, 32'h0,        32'h0,         0, 1, 0, 1, 0, 0, 32'h0);
    vecs[20] = mk(0, 0, 10'h000, 32'h0,        32'h0,         0, 0, 10'h000, 32'h0,        32'h0,         0, 0, 1, 1, 0, 1, 32'hFFFFABCD);

    // Reset state, with requests up to show nothing is granted.
    drv_m0(1, 0, 10'h001, '0, '0);
    drv_m1(1, 0, 10'h002, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   busy, 1);
    check("rst_cen",    ram_cen, 1);
    check("rst_gnt",    {m0_gnt, m1_gnt}, 0);
    check("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    check("rst_perr",   perr, 0);
    tick();
    reset = 1'b0;

    // Power-on scrub sweep: exactly DEPTH cycles of zero writes, no grants.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check($sformatf("scrub0_%0d", i),
            {busy, ram_cen, ram_gwen, m0_gnt, m1_gnt, 22'(ram_a), ram_wen},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 22'(i), 36'h0});
      if (ram_d !== '0) check($sformatf("scrub0_d_%0d", i), ram_d, 0);
    end
    tick();
    drv_m0(0, 0, '0, '0, '0);
    drv_m1(0, 0, '0, '0, '0);
    @(negedge clk);
    check("scrub0_done_busy", busy, 0);
    check("idle_cen", {ram_cen, ram_gwen, ram_wen}, {2'b11, 36'hF_FFFF_FFFF});

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 21; i++) begin
      tick();
      drv_m0(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0, vecs[i].k0);
      drv_m1(vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1, vecs[i].k1);
      @(negedge clk);
      check($sformatf("v%0d_gnt", i), {m0_gnt, m1_gnt}, {vecs[i].eg0, vecs[i].eg1});
      check($sformatf("v%0d_cen_gwen", i), {ram_cen, ram_gwen}, {vecs[i].ecen, vecs[i].egwen});
      check($sformatf("v%0d_rvalid", i), {m0_rvalid, m1_rvalid}, {vecs[i].erv0, vecs[i].erv1});
      if (vecs[i].erv0) check($sformatf("v%0d_m0_rdata", i), m0_rdata, vecs[i].erd);
      if (vecs[i].erv1) check($sformatf("v%0d_m1_rdata", i), m1_rdata, vecs[i].erd);
    end
    check("perr_clean", perr, 0);

    // Zeroize with a read in flight and m1 waiting.
    tick();
    drv_m0(1, 0, 10'h3FF, '0, '0);
    @(negedge clk);
    check("z_pre_gnt", {m0_gnt, m1_gnt}, 2'b10);
    if (m0_gnt) exp_q.push_back(32'hDEADBEEF);
    tick();
    drv_m0(0, 0, '0, '0, '0);
    drv_m1(1, 0, 10'h010, '0, '0);
    zeroize = 1'b1;
    @(negedge clk);
    check("z_cycle_gnt", {m0_gnt, m1_gnt}, 0);
    check("z_cycle_cen", ram_cen, 1);
    check("z_cycle_busy", busy, 0);
    check("z_cycle_rvalid", {m0_rvalid, m1_rvalid}, 2'b10);
    if (m0_rvalid && exp_q.size() > 0) check("z_cycle_rdata", m0_rdata, exp_q.pop_front());
    tick();
    zeroize = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check($sformatf("scrub1_%0d", i),
            {busy, ram_cen, ram_gwen, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, 22'(ram_a)},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 22'(i)});
    end
    @(negedge clk);
    check("z_done_busy", busy, 0);
    check("z_done_gnt", {m0_gnt, m1_gnt}, 2'b01);
    if (m1_gnt) exp_q.push_back(32'h0);
    tick();
    drv_m1(0, 0, '0, '0, '0);
    @(negedge clk);
    check("z_m1_rvalid", {m0_rvalid, m1_rvalid}, 2'b01);
    if (m1_rvalid && exp_q.size() > 0) check("z_m1_rdata", m1_rdata, exp_q.pop_front());
    check("z_exp_q_empty", exp_q.size(), 0);
    check("perr_after_z", perr, 0);

`ifdef SCE_RAMARB_PARITY_EN
    // Corrupt stored parity bit 0 on the read return of 0x01020304.
    tick();
    drv_m0(1, 1, 10'h040, 32'h01020304, 32'hFFFFFFFF);
    @(negedge clk);
    check("p_wr_parity", {ram_d[DW+3:DW], ram_wen[DW+3:DW]}, {4'b1101, 4'b0000});
    tick();
    drv_m0(1, 0, 10'h040, '0, '0);
    tick();
    drv_m0(0, 0, '0, '0, '0);
    q_flip = 36'h1_0000_0000;
    @(negedge clk);
    check("p_rvalid", m0_rvalid, 1);
    check("p_perr_set", perr, 1);
    tick();
    q_flip = '0;
    repeat (3) begin
      @(negedge clk);
      check("p_perr_sticky", perr, 1);
    end
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("p_perr_reset", perr, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
